// File: rtl/trdb_branch_map_unpacker.sv
// Replays a packed branch map (bit 0 oldest, 1 = not taken) as single taken flags; first outcome one cycle after accept.
// Stalls on br_ready_i with stable outputs; takes the next map in the cycle the last outcome is consumed.
module trdb_branch_map_unpacker #(
  parameter int MAP_LEN = 31,
  parameter int CNT_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               map_valid_i,
  output logic               map_ready_o,
  input  logic [MAP_LEN-1:0] map_i,
  input  logic [CNT_W-1:0]   branches_i,
  output logic               br_valid_o,
  input  logic               br_ready_i,
  output logic               br_taken_o,
  output logic               br_last_o,
  output logic [CNT_W-1:0]   br_idx_o,
  output logic               empty_map_o,
  output logic               busy_o
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_in;
  logic               empty_q, empty_d;
  logic               drain, last, consume, accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      map_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      empty_q <= empty_d;
    end
  end

  always_comb begin
    drain   = (state_q == DRAIN);
    last    = drain && (idx_q == cnt_q - CNT_W'(1));
    consume = drain && br_ready_i;
    // Counts wider than the map are clamped so idx_q never runs past the last stored bit.
    cnt_in  = (int'(branches_i) > MAP_LEN) ? CNT_W'(MAP_LEN) : branches_i;

    map_ready_o = !rst_i && !flush_i && (!drain || (last && br_ready_i));
    accept      = map_valid_i && map_ready_o;

    br_valid_o  = drain;
    br_taken_o  = drain && !map_q[idx_q];
    br_last_o   = last;
    br_idx_o    = drain ? idx_q : '0;
    busy_o      = drain;
    empty_map_o = empty_q;

    state_d = state_q;
    map_d   = map_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    empty_d = 1'b0;

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (consume) begin
        if (last) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      if (accept) begin
        if (cnt_in == '0) begin
          state_d = IDLE;
          empty_d = 1'b1;
        end else begin
          state_d = DRAIN;
          map_d   = map_i;
          cnt_d   = cnt_in;
          idx_d   = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_trdb_branch_map_unpacker.sv
// Bench: queue-of-outcomes model checked every negedge, plus directed scenarios with literal expectations.
module tb_trdb_branch_map_unpacker;
  localparam int MAP_LEN = 31;
  localparam int CNT_W   = 5;

  logic               clk = 1'b0;
  logic               rst, flush, map_valid, map_ready, br_valid, br_ready;
  logic               br_taken, br_last, empty_map, busy;
  logic [MAP_LEN-1:0] map_in;
  logic [CNT_W-1:0]   branches, br_idx;

  trdb_branch_map_unpacker #(.MAP_LEN(MAP_LEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .map_valid_i(map_valid), .map_ready_o(map_ready),
    .map_i(map_in), .branches_i(branches),
    .br_valid_o(br_valid), .br_ready_i(br_ready),
    .br_taken_o(br_taken), .br_last_o(br_last), .br_idx_o(br_idx),
    .empty_map_o(empty_map), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tk;
    logic [4:0] idx;
    logic       last;
  } ent_t;

  ent_t q[$];
  bit   emp_m = 1'b0;
  int   total = 0, bad = 0;
  int   cyc = 0, emp_cnt = 0, vld_cnt = 0;
  int   lg_tk[$], lg_idx[$], lg_last[$], lg_cyc[$];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: pending outcomes of accepted maps, oldest at the front.
  always @(negedge clk) begin : cmp
    bit rdy_m;
    bit acc;
    int n;
    ent_t e;
    cyc++;
    rdy_m = !rst && !flush && (q.size() == 0 || (q.size() == 1 && br_ready));
    chk("map_ready", int'(map_ready), int'(rdy_m));
    chk("br_valid", int'(br_valid), int'(q.size() > 0));
    chk("busy", int'(busy), int'(q.size() > 0));
    chk("empty_map", int'(empty_map), int'(emp_m));
    if (q.size() > 0) begin
      chk("br_taken", int'(br_taken), int'(q[0].tk));
      chk("br_idx", int'(br_idx), int'(q[0].idx));
      chk("br_last", int'(br_last), int'(q[0].last));
    end
    if (br_valid) vld_cnt++;
    if (empty_map) emp_cnt++;
    if (br_valid && br_ready && !rst && !flush) begin
      lg_tk.push_back(int'(br_taken));
      lg_idx.push_back(int'(br_idx));
      lg_last.push_back(int'(br_last));
      lg_cyc.push_back(cyc);
    end
    if (rst || flush) begin
      q.delete();
      emp_m = 1'b0;
    end else begin
      acc = map_valid && rdy_m;
      if (q.size() > 0 && br_ready) void'(q.pop_front());
      n = (int'(branches) > MAP_LEN) ? MAP_LEN : int'(branches);
      emp_m = acc && (n == 0);
      if (acc) begin
        for (int i = 0; i < n; i++) begin
          e.tk   = !map_in[i];
          e.idx  = 5'(i);
          e.last = (i == n - 1);
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic log_chk(string nm, int base, int i, int tk, int idx, int last);
    if (lg_tk.size() <= base + i) begin
      chk({nm, "_missing"}, lg_tk.size(), base + i + 1);
    end else begin
      chk({nm, "_taken"}, lg_tk[base + i], tk);
      chk({nm, "_idx"}, lg_idx[base + i], idx);
      chk({nm, "_last"}, lg_last[base + i], last);
    end
  endtask

  task automatic consec_chk(string nm, int base, int n);
    for (int i = 1; i < n; i++)
      if (lg_cyc.size() > base + i)
        chk({nm, "_consec"}, lg_cyc[base + i] - lg_cyc[base], i);
  endtask

  initial begin
    int base, e0, v0;
    rst = 1; flush = 0; map_valid = 0; br_ready = 0; map_in = '0; branches = '0;
    tick(2);
    rst = 0;

    // Reset mid-drain
    map_in = 31'b1010; branches = 4; map_valid = 1;
    tick(1);
    map_valid = 0;
    tick(2);
    rst = 1;
    tick(2);
    rst = 0;
    @(negedge clk);
    chk("rst_br_valid", int'(br_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_map_ready", int'(map_ready), 1);
    tick(1);

    // Three-branch map 101
    base = lg_tk.size();
    br_ready = 1; map_in = 31'b101; branches = 3; map_valid = 1;
    tick(1);
    map_valid = 0;
    @(negedge clk);
    chk("lat_first_valid", int'(br_valid), 1);
    tick(5);
    chk("b_count", lg_tk.size() - base, 3);
    log_chk("b0", base, 0, 0, 0, 0);
    log_chk("b1", base, 1, 1, 1, 0);
    log_chk("b2", base, 2, 0, 2, 1);
    consec_chk("b", base, 3);

    // Empty map
    e0 = emp_cnt; v0 = vld_cnt;
    map_in = '1; branches = 0; map_valid = 1;
    tick(1);
    map_valid = 0;
    tick(3);
    chk("empty_pulses", emp_cnt - e0, 1);
    chk("empty_no_valid", vld_cnt - v0, 0);

    // Full map with stalls
    base = lg_tk.size();
    map_in = '0; branches = 31; map_valid = 1;
    tick(1);
    map_valid = 0;
    for (int i = 0; i < 70; i++) begin
      br_ready = (i % 2 == 1);
      tick(1);
    end
    br_ready = 1;
    tick(2);
    chk("full_count", lg_tk.size() - base, 31);
    for (int i = 0; i < 31; i++) log_chk("full", base, i, 1, i, int'(i == 30));

    // Back-to-back maps with map_valid held
    base = lg_tk.size();
    br_ready = 1; map_in = 31'b10; branches = 2; map_valid = 1;
    tick(1);
    map_in = 31'b1; branches = 1;
    tick(2);
    map_valid = 0;
    tick(3);
    chk("b2b_count", lg_tk.size() - base, 3);
    log_chk("b2b0", base, 0, 1, 0, 0);
    log_chk("b2b1", base, 1, 0, 1, 1);
    log_chk("b2b2", base, 2, 0, 0, 1);
    consec_chk("b2b", base, 3);

    // Flush at idx 1 of a four-branch map
    base = lg_tk.size();
    map_in = '0; branches = 4; map_valid = 1;
    tick(1);
    map_valid = 0;
    tick(1);
    flush = 1; map_in = 31'b11; branches = 2; map_valid = 1;
    @(negedge clk);
    chk("flush_idx", int'(br_idx), 1);
    chk("flush_no_ready", int'(map_ready), 0);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("post_flush_valid", int'(br_valid), 0);
    chk("post_flush_busy", int'(busy), 0);
    @(posedge clk); #1;
    map_valid = 0;
    @(negedge clk);
    chk("new_map_valid", int'(br_valid), 1);
    tick(4);
    chk("flush_count", lg_tk.size() - base, 3);
    log_chk("fl0", base, 0, 1, 0, 0);
    log_chk("fl1", base, 1, 0, 0, 0);
    log_chk("fl2", base, 2, 0, 1, 1);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
